// File: rtl/hsid_pkg.sv
// Shared widths and types for the hyperspectral identification datapath.
package hsid_pkg;

  localparam int unsigned HSID_WORD_WIDTH        = 32;
  localparam int unsigned HSID_DATA_WIDTH        = 16;
  localparam int unsigned HSID_HSP_BANDS_WIDTH   = 7;
  localparam int unsigned HSID_HSP_LIBRARY_WIDTH = 6;
  localparam int unsigned HSID_FIFO_ADDR_WIDTH   = 2;
  // Word address into pixel memory is {pixel_idx, band_idx}.
  localparam int unsigned HSID_MEM_ACCESS_WIDTH  = HSID_HSP_BANDS_WIDTH + HSID_HSP_LIBRARY_WIDTH;

  typedef enum logic [2:0] {
    W_IDLE,
    W_CAPTURE,
    W_DRAIN,
    W_DONE,
    W_ERROR
  } hsid_writer_state_t;

endpackage

// File: rtl/hsid_fifo.sv
// Small synchronous FIFO with registered full/empty flags and a synchronous flush.
module hsid_fifo #(
  parameter int unsigned DATA_WIDTH = 45,
  parameter int unsigned ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [ADDR_WIDTH-1:0] wptr_q, rptr_q;
  logic [ADDR_WIDTH:0]   cnt_q;
  logic                  do_push, do_pop;

  assign full    = (cnt_q == (ADDR_WIDTH + 1)'(Depth));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/hsid_hsp_writer.sv
// Capture-side writer: streams one pixel's bands through a FIFO into pixel memory
// at word address {pixel_idx, band_idx}.
module hsid_hsp_writer
  import hsid_pkg::*;
#(
  parameter int unsigned WORD_WIDTH      = HSID_WORD_WIDTH,
  parameter int unsigned DATA_WIDTH      = HSID_DATA_WIDTH,
  parameter int unsigned BANDS_WIDTH     = HSID_HSP_BANDS_WIDTH,
  parameter int unsigned LIBRARY_WIDTH   = HSID_HSP_LIBRARY_WIDTH,
  parameter int unsigned FIFO_ADDR_WIDTH = HSID_FIFO_ADDR_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 start,
  input  logic [BANDS_WIDTH-1:0]               num_bands,
  input  logic [LIBRARY_WIDTH-1:0]             pixel_idx,
  input  logic                                 band_valid,
  output logic                                 band_ready,
  input  logic [DATA_WIDTH-1:0]                band_data,
  input  logic                                 band_last,
  output logic                                 mem_req,
  input  logic                                 mem_gnt,
  output logic                                 mem_we,
  output logic [BANDS_WIDTH+LIBRARY_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]                mem_wdata,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic                                 overflow
);

  localparam int unsigned AddrWidth  = BANDS_WIDTH + LIBRARY_WIDTH;
  localparam int unsigned EntryWidth = AddrWidth + WORD_WIDTH;

  hsid_writer_state_t state_q, state_d;

  logic [BANDS_WIDTH-1:0]   num_bands_q, band_cnt_q;
  logic [LIBRARY_WIDTH-1:0] pixel_idx_q;
  logic                     overflow_q;

  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [EntryWidth-1:0] fifo_wdata, fifo_rdata;
  logic                  accept, is_final, cfg_load;

  assign is_final = (band_cnt_q == num_bands_q - BANDS_WIDTH'(1));
  assign cfg_load = (state_q == W_IDLE) && start && (num_bands != '0) && !clear;

  // No pass-through: readiness depends on the registered full flag only.
  assign band_ready = (state_q == W_CAPTURE) && !fifo_full && !clear;
  assign accept     = band_valid && band_ready;
  // A final band missing its last marker is consumed but never written.
  assign fifo_push  = accept && !(is_final && !band_last);
  assign fifo_wdata = {pixel_idx_q, band_cnt_q, WORD_WIDTH'(band_data[13:0])};

  assign mem_req   = !fifo_empty;
  assign mem_we    = mem_req;
  assign fifo_pop  = mem_req && mem_gnt;
  assign mem_addr  = mem_req ? fifo_rdata[EntryWidth-1:WORD_WIDTH] : '0;
  assign mem_wdata = mem_req ? fifo_rdata[WORD_WIDTH-1:0] : '0;

  assign busy     = (state_q != W_IDLE);
  assign done     = (state_q == W_DONE);
  assign error    = (state_q == W_ERROR);
  assign overflow = overflow_q;

  hsid_fifo #(
    .DATA_WIDTH (EntryWidth),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= W_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE: begin
        if (start) state_d = (num_bands != '0) ? W_CAPTURE : W_ERROR;
      end
      W_CAPTURE: begin
        if (accept) begin
          if (is_final)       state_d = band_last ? W_DRAIN : W_ERROR;
          else if (band_last) state_d = W_ERROR;
        end
      end
      W_DRAIN:  if (fifo_empty) state_d = W_DONE;
      W_DONE:   state_d = W_IDLE;
      W_ERROR:  state_d = W_ERROR;
      default:  state_d = W_IDLE;
    endcase
    if (clear) state_d = W_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      num_bands_q <= '0;
      pixel_idx_q <= '0;
      band_cnt_q  <= '0;
      overflow_q  <= 1'b0;
    end else if (clear) begin
      band_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (cfg_load) begin
        num_bands_q <= num_bands;
        pixel_idx_q <= pixel_idx;
        band_cnt_q  <= '0;
      end
      if (accept) begin
        band_cnt_q <= band_cnt_q + BANDS_WIDTH'(1);
        if (|band_data[DATA_WIDTH-1:14]) overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hsid_hsp_writer.sv
// Randomised self-checking bench for hsid_hsp_writer against a queue-based write model.
module tb_hsid_hsp_writer;
  import hsid_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear, start, band_valid, band_ready, band_last;
  logic [6:0]  num_bands;
  logic [5:0]  pixel_idx;
  logic [15:0] band_data;
  logic        mem_req, mem_gnt, mem_we, busy, done, error, overflow;
  logic [12:0] mem_addr;
  logic [31:0] mem_wdata;

  hsid_hsp_writer u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .start      (start),
    .num_bands  (num_bands),
    .pixel_idx  (pixel_idx),
    .band_valid (band_valid),
    .band_ready (band_ready),
    .band_data  (band_data),
    .band_last  (band_last),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: expected writes in order, outstanding-entry count, flags.
  logic [44:0] exp_q[$];
  logic [15:0] bdata [128];
  int          occ;
  bit          capturing, cur_pushes, acc, exp_ovf;
  int          done_cnt, done_cyc, cyc;

  task automatic tick();
    logic [44:0] e;
    #1;
    check_eq("mem_req", mem_req, occ != 0);
    check_eq("band_ready", band_ready, capturing && (occ < 4) && !clear);
    acc = band_valid && band_ready;
    if (mem_req && mem_gnt) begin
      check_eq("write_expected", exp_q.size() != 0, 1);
      check_eq("mem_we", mem_we, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("mem_addr", mem_addr, e[44:32]);
        check_eq("mem_wdata", mem_wdata, e[31:0]);
      end
      occ--;
    end
    if (acc && cur_pushes) occ++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_clear();
    clear   = 1'b1;
    mem_gnt = 1'b0;
    tick();
    clear     = 1'b0;
    occ       = 0;
    capturing = 1'b0;
    exp_ovf   = 1'b0;
    exp_q.delete();
    check_eq("clear_error", error, 0);
    check_eq("clear_overflow", overflow, 0);
    check_eq("clear_busy", busy, 0);
  endtask

  // err_at < 0: legal pixel; err_at < nb-1: early last; err_at == nb-1: missing last.
  task automatic run_pixel(input int nb, input int px, input int err_at, input int gnt_pct,
                           input int gnt_hold, input int valid_pct, input bit busy_start);
    logic [5:0] p;
    int k, last_k;
    p = px[5:0];
    for (int i = 0; i < nb; i++) begin
      if (i == err_at && err_at == nb - 1) break;
      exp_q.push_back({p, i[6:0], 16'h0000, bdata[i] & 16'h3FFF});
      if (bdata[i][15:14] != 2'b00) exp_ovf = 1'b1;
      if (i == err_at) break;
    end
    done_cnt   = 0;
    done_cyc   = -1;
    cyc        = 0;
    cur_pushes = 1'b0;
    start      = 1'b1;
    num_bands  = nb[6:0];
    pixel_idx  = p;
    mem_gnt    = 1'b0;
    tick();
    start     = 1'b0;
    capturing = 1'b1;
    k         = 0;
    last_k    = (err_at >= 0) ? err_at : nb - 1;
    while (k <= last_k && cyc < 3000) begin
      band_valid = ($urandom_range(99) < valid_pct);
      band_data  = bdata[k];
      band_last  = (k == nb - 1);
      if (k == err_at) band_last = ~band_last;
      cur_pushes = !(k == nb - 1 && !band_last);
      mem_gnt    = (cyc <= gnt_hold) ? 1'b0 : ($urandom_range(99) < gnt_pct);
      if (busy_start) begin
        start     = ($urandom_range(3) == 0);
        num_bands = 7'($urandom);
        pixel_idx = 6'($urandom);
      end
      tick();
      if (acc) begin
        k++;
        if (k > last_k) capturing = 1'b0;
      end
      if (gnt_hold >= 5 && valid_pct == 100 && cyc == gnt_hold + 1)
        check_eq("accepted_while_stalled", k, 4);
    end
    band_valid = 1'b0;
    start      = 1'b0;
    cur_pushes = 1'b0;
    while (cyc < 3000 && ((err_at >= 0) ? (occ != 0) : (done_cnt == 0))) begin
      mem_gnt = ($urandom_range(99) < gnt_pct);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      mem_gnt = 1'b1;
      tick();
    end
    check_eq("queue_drained", exp_q.size(), 0);
    check_eq("error", error, err_at >= 0);
    check_eq("overflow", overflow, exp_ovf);
    check_eq("done_count", done_cnt, (err_at >= 0) ? 0 : 1);
    check_eq("busy_after", busy, err_at >= 0);
    if (err_at < 0 && gnt_pct == 100 && valid_pct == 100 && gnt_hold < 0)
      check_eq("start_to_done", done_cyc, nb + 3);
    if (err_at >= 0) do_clear();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, ep;
    clear = 0; start = 0; num_bands = 0; pixel_idx = 0;
    band_valid = 0; band_data = 0; band_last = 0; mem_gnt = 0;
    occ = 0; capturing = 0; cur_pushes = 0; exp_ovf = 0;
    #1;
    check_eq("rst_band_ready", band_ready, 0);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_flags", {busy, done, error, overflow}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_mem_req", mem_req, 0);

    // Three bands into pixel 5, grant always high.
    bdata[0] = 16'h0011; bdata[1] = 16'h0022; bdata[2] = 16'h0033;
    run_pixel(3, 5, -1, 100, -1, 100, 0);

    // Grant held low: four entries fill, then stall, then all drain in order.
    for (int i = 0; i < 8; i++) bdata[i] = 16'(i * 16'h0101 + 1);
    run_pixel(8, 9, -1, 100, 10, 100, 0);

    // Early last on band 2 of 4.
    for (int i = 0; i < 4; i++) bdata[i] = 16'(16'h0100 + i);
    run_pixel(4, 17, 2, 100, -1, 100, 0);

    // Missing last on the final band.
    run_pixel(4, 18, 3, 100, -1, 100, 0);

    // Zero bands goes straight to error without touching memory.
    start = 1'b1; num_bands = 0; pixel_idx = 6'd3; cur_pushes = 1'b0; mem_gnt = 1'b1;
    tick();
    start = 1'b0; band_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    band_valid = 1'b0;
    check_eq("zero_bands_error", error, 1);
    do_clear();

    // Masked data with overflow reporting.
    bdata[0] = 16'hC005; bdata[1] = 16'h4FFF;
    run_pixel(2, 1, -1, 100, -1, 100, 0);
    do_clear();

    // Clear mid-capture with the memory port stalled.
    start = 1'b1; num_bands = 7'd10; pixel_idx = 6'd7; mem_gnt = 1'b0; cur_pushes = 1'b0;
    tick();
    start = 1'b0; capturing = 1'b1; cur_pushes = 1'b1;
    band_valid = 1'b1; band_data = 16'hC005; band_last = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    band_valid = 1'b0;
    check_eq("midcap_overflow", overflow, 1);
    do_clear();
    band_valid = 1'b1; mem_gnt = 1'b1; cur_pushes = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    band_valid = 1'b0;

    // Full-size pixel in the highest slot.
    for (int i = 0; i < 127; i++) bdata[i] = 16'($urandom) & 16'h3FFF;
    run_pixel(127, 63, -1, 100, -1, 100, 0);

    // Randomised pixels, sometimes malformed, with spurious starts while busy.
    for (int t = 0; t < 30; t++) begin
      nb = $urandom_range(16, 1);
      for (int i = 0; i < nb; i++) begin
        bdata[i] = 16'($urandom);
        if ($urandom_range(3) != 0) bdata[i][15:14] = 2'b00;
      end
      ep = ($urandom_range(3) == 0) ? int'($urandom_range(nb - 1)) : -1;
      if (ep == nb - 1) bdata[nb-1][15:14] = 2'b00;
      run_pixel(nb, int'($urandom_range(63)), ep, int'($urandom_range(100, 30)), -1,
                int'($urandom_range(100, 40)), 1);
      if ($urandom_range(4) == 0) do_clear();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
